// File: rtl/udp_sweep_pkg.sv
// Shared types and sizes for the truth-table sweeper.
// Vector count and index width follow from the 3-input block under sweep.
package udp_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 8;
  localparam int IDX_W       = 3;

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle counter: load clears, en increments; expired flags the last settle cycle.
// Latency: expired is combinational from the registered count.
module sweep_settle_timer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/udp_truth_sweeper.sv
// Drives all eight x/y/z vectors into a 3-input logic block, samples f after a
// programmable settle time, and compares the captured truth table with a golden one.
module udp_truth_sweeper
  import udp_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       f,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       pass,
  output logic [7:0] mismatch
);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       exp_q;
  logic [7:0]       table_nxt;
  logic             load;
  logic             en;
  logic             expired;

  assign load = ((state == IDLE) && start) || (state == SAMPLE);
  assign en   = (state == SETTLE);

  sweep_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .en     (en),
    .expired(expired)
  );

  // Table with the current sample merged in, so the verdict can be registered
  // on the same edge that captures the last bit.
  always_comb begin
    table_nxt      = table_out;
    table_nxt[idx] = f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      exp_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
      pass      <= 1'b0;
      mismatch  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            exp_q     <= expected;
            table_out <= '0;
            pass      <= 1'b0;
            mismatch  <= '0;
            idx       <= '0;
            busy      <= 1'b1;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          if (expired) state <= SAMPLE;
        end
        SAMPLE: begin
          table_out <= table_nxt;
          if (idx == IDX_W'(NUM_VECTORS - 1)) begin
            done     <= 1'b1;
            pass     <= (table_nxt == exp_q);
            mismatch <= table_nxt ^ exp_q;
            state    <= DONE;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= SETTLE;
          end
        end
        DONE: begin
          // Park the block inputs at 000 while idle.
          busy  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign x = idx[2];
  assign y = idx[1];
  assign z = idx[0];

endmodule

// File: tb/tb_udp_truth_sweeper.sv
module tb_udp_truth_sweeper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, start1;
  logic [7:0] expected;
  logic       f0, f1;
  logic       x0, y0, z0, busy0, done0, pass0;
  logic       x1, y1, z1, busy1, done1, pass1;
  logic [7:0] tbl0, mm0, tbl1, mm1;

  int         mode;
  logic [7:0] lut;
  logic       sel;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  // Behavioural models of the logic block under sweep.
  function automatic logic fmodel(input int m, input logic [7:0] l, input logic [2:0] v);
    case (m)
      0:       return (v[2] & v[1]) | (v[1] & v[0]) | (v[2] & v[0]);
      1:       return ^v;
      2:       return 1'b1;
      default: return l[v];
    endcase
  endfunction

  function automatic logic [7:0] ref_table(input int m, input logic [7:0] l);
    logic [7:0] t;
    for (int i = 0; i < 8; i++) t[i] = fmodel(m, l, 3'(i));
    return t;
  endfunction

  assign f0 = fmodel(mode, lut, {x0, y0, z0});
  assign f1 = fmodel(mode, lut, {x1, y1, z1});

  udp_truth_sweeper #(.SETTLE_CYCLES(2), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .expected(expected), .f(f0),
    .x(x0), .y(y0), .z(z0), .busy(busy0), .done(done0),
    .table_out(tbl0), .pass(pass0), .mismatch(mm0)
  );

  udp_truth_sweeper #(.SETTLE_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(expected), .f(f1),
    .x(x1), .y(y1), .z(z1), .busy(busy1), .done(done1),
    .table_out(tbl1), .pass(pass1), .mismatch(mm1)
  );

  wire [2:0] xyz_m  = sel ? {x1, y1, z1} : {x0, y0, z0};
  wire       busy_m = sel ? busy1 : busy0;
  wire       done_m = sel ? done1 : done0;
  wire [7:0] tbl_m  = sel ? tbl1 : tbl0;
  wire       pass_m = sel ? pass1 : pass0;
  wire [7:0] mm_m   = sel ? mm1 : mm0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_start(input logic s, input logic v);
    if (s) start1 = v; else start0 = v;
  endtask

  task automatic run_sweep(input logic s, input int m, input logic [7:0] l, input logic [7:0] exp,
                           input bit glitch, input logic [7:0] e_tbl, input logic e_pass,
                           input logic [7:0] e_mm);
    int   per;
    int   done_k;
    int   ei;
    bit   xyz_ok, busy_ok;
    per     = s ? 2 : 3;
    done_k  = -1;
    xyz_ok  = 1;
    busy_ok = 1;
    sel  = s;
    mode = m;
    lut  = l;
    @(negedge clk);
    expected = exp;
    set_start(s, 1'b1);
    @(posedge clk);          // E0
    #1;
    set_start(s, 1'b0);
    expected = ~exp;         // only the latched copy may matter
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) check("start_clears", {tbl_m, pass_m, mm_m}, 17'h0);
      set_start(s, glitch && (k == 5 || k == 20));
      ei = (k < 8 * per) ? k / per : 7;
      if (xyz_m !== 3'(ei)) xyz_ok = 0;
      if (busy_m !== 1'b1) busy_ok = 0;
      if (done_m === 1'b1) begin
        done_k = k;
        break;
      end
    end
    set_start(s, 1'b0);
    check("done_latency", done_k, 8 * per);
    check("xyz_sequence", xyz_ok, 1);
    check("busy_high", busy_ok, 1);
    check("table_out", tbl_m, e_tbl);
    check("pass", pass_m, e_pass);
    check("mismatch", mm_m, e_mm);
    @(negedge clk);
    check("done_single_pulse", done_m, 0);
    check("busy_low_after", busy_m, 0);
    check("xyz_idle", xyz_m, 0);
    check("results_held", {tbl_m, pass_m, mm_m}, {e_tbl, e_pass, e_mm});
  endtask

  typedef struct {
    logic       s;
    int         m;
    logic [7:0] exp;
    bit         glitch;
    logic [7:0] tbl;
    logic       ok;
    logic [7:0] mm;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 0, 8'hE8, 1'b0, 8'hE8, 1'b1, 8'h00};
    vecs[1] = '{1'b0, 1, 8'h97, 1'b0, 8'h96, 1'b0, 8'h01};
    vecs[2] = '{1'b0, 1, 8'h96, 1'b0, 8'h96, 1'b1, 8'h00};
    vecs[3] = '{1'b0, 0, 8'hE8, 1'b1, 8'hE8, 1'b1, 8'h00};
    vecs[4] = '{1'b1, 2, 8'hFF, 1'b0, 8'hFF, 1'b1, 8'h00};
    vecs[5] = '{1'b1, 1, 8'h00, 1'b0, 8'h96, 1'b0, 8'h96};

    sel = 0; mode = 0; lut = 0; expected = 8'h00;
    rst_n = 1'b0; start0 = 1'b1; start1 = 1'b1;
    #1;
    check("reset_outputs0", {x0, y0, z0, busy0, done0, tbl0, pass0, mm0}, 0);
    check("reset_outputs1", {x1, y1, z1, busy1, done1, tbl1, pass1, mm1}, 0);
    repeat (3) @(negedge clk);
    check("reset_held_start", {busy0, done0, busy1, done1}, 0);
    start0 = 1'b0; start1 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {x0, y0, z0, busy0, x1, y1, z1, busy1}, 0);

    foreach (vecs[i])
      run_sweep(vecs[i].s, vecs[i].m, vecs[i].exp, vecs[i].exp, vecs[i].glitch,
                vecs[i].tbl, vecs[i].ok, vecs[i].mm);

    // Asynchronous reset while vector 4 is presented.
    sel = 0; mode = 0;
    @(negedge clk);
    expected = 8'hE8; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int k = 0; k < 30 && {x0, y0, z0} != 3'd4; k++) @(negedge clk);
    check("reached_idx4", {x0, y0, z0}, 3'd4);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset", {x0, y0, z0, busy0, done0, tbl0, pass0, mm0}, 0);
    @(negedge clk);
    check("no_done_after_abort", done0, 0);
    rst_n = 1'b1;
    run_sweep(1'b0, 0, 8'h00, 8'hE8, 1'b0, 8'hE8, 1'b1, 8'h00);

    // Random truth tables against the reference model.
    for (int r = 0; r < 12; r++) begin
      logic [7:0] l, e, t;
      logic       s;
      l = 8'($urandom);
      e = $urandom_range(0, 1) ? l : 8'($urandom);
      s = 1'($urandom_range(0, 1));
      t = ref_table(3, l);
      run_sweep(s, 3, l, e, 1'b0, t, (t == e), t ^ e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
